// File: rtl/mem_arbiter_if.sv
// Cache-to-RAM arbitration bus: per-cache request lanes, grants and the shared RAM port.
// master: the arbiter; slave: the caches plus the RAM that surround it.
interface mem_arbiter_if #(
  parameter int PORTS      = 2,
  parameter int DATA_WIDTH = 10,
  parameter int ADDR_WIDTH = 14
);
  logic [PORTS-1:0]            req_read;
  logic [PORTS-1:0]            req_write;
  logic [PORTS*ADDR_WIDTH-1:0] req_addr;
  logic [PORTS*DATA_WIDTH-1:0] req_wdata;
  logic [PORTS-1:0]            grant;
  logic [DATA_WIDTH-1:0]       rdata;
  logic [ADDR_WIDTH-1:0]       ram_addr;
  logic                        ram_read;
  logic                        ram_write;
  logic [DATA_WIDTH-1:0]       ram_data_in;
  logic [DATA_WIDTH-1:0]       ram_data_out;

  modport master (
    input  req_read, req_write, req_addr, req_wdata,
    input  ram_data_out,
    output grant, rdata,
    output ram_addr, ram_read, ram_write, ram_data_in
  );

  modport slave (
    output req_read, req_write, req_addr, req_wdata,
    output ram_data_out,
    input  grant, rdata,
    input  ram_addr, ram_read, ram_write, ram_data_in
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin shared-RAM arbiter; ownership is locked for a whole miss burst.
// Define MEM_ARB_STATS_EN to add the D_GRANTS / D_WAIT debug counters.
module mem_arbiter #(
  parameter int PORTS      = 2,
  parameter int DATA_WIDTH = 10,
  parameter int ADDR_WIDTH = 14,
  parameter int PORT_LEN   = $clog2(PORTS)
) (
  input  logic                clk,
  input  logic                rst_n,
  mem_arbiter_if.master       bus,
  output logic [PORT_LEN-1:0] D_OWNER,
  output logic [1:0]          D_STATE
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [PORTS*16-1:0] D_GRANTS,
  output logic [15:0]         D_WAIT
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN  = 2'd1,
    TAIL = 2'd2
  } state_t;

  state_t              state;
  logic [PORT_LEN-1:0] owner;
  logic [PORT_LEN-1:0] rr_ptr;
  logic [PORT_LEN-1:0] pick;
  logic [PORT_LEN-1:0] nxt_ptr;
  logic [PORTS-1:0]    req;
  logic                any_req;
  logic                own_req;
  logic                active;
  logic                wr;

  assign req     = bus.req_read | bus.req_write;
  assign any_req = |req;
  assign own_req = req[owner];
  assign active  = (state != IDLE);

  assign nxt_ptr = (owner == PORT_LEN'(PORTS-1))
                 ? '0 : owner + 1'b1;

  // First requester at or above rr_ptr, wrapping; low offsets win.
  always_comb begin
    pick = rr_ptr;
    for (int k = PORTS-1; k >= 0; k--) begin
      if (req[(int'(rr_ptr) + k) % PORTS]) begin
        pick = PORT_LEN'((int'(rr_ptr) + k) % PORTS);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      owner     <= '0;
      rr_ptr    <= '0;
      bus.grant <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (any_req) begin
            owner     <= pick;
            bus.grant <= PORTS'(1) << pick;
            state     <= OWN;
          end
        end
        OWN: begin
          if (!own_req) state <= TAIL;
        end
        TAIL: begin
          if (own_req) begin
            state <= OWN;
          end else begin
            state     <= IDLE;
            bus.grant <= '0;
            rr_ptr    <= nxt_ptr;
          end
        end
        default: begin
          state     <= IDLE;
          bus.grant <= '0;
        end
      endcase
    end
  end

  // Write has priority when the owner raises both strobes.
  assign wr = active & bus.req_write[owner];

  assign bus.ram_write = wr;
  assign bus.ram_read  = active & bus.req_read[owner] & ~wr;

  assign bus.ram_addr = active
    ? bus.req_addr[int'(owner)*ADDR_WIDTH +: ADDR_WIDTH]
    : '0;

  assign bus.ram_data_in = active
    ? bus.req_wdata[int'(owner)*DATA_WIDTH +: DATA_WIDTH]
    : '0;

  assign bus.rdata = bus.ram_data_out;
  assign D_OWNER   = owner;
  assign D_STATE   = state;

`ifdef MEM_ARB_STATS_EN
  logic [PORTS-1:0] own_mask;
  logic             waiting;

  assign own_mask = PORTS'(1) << owner;
  assign waiting  = active & (|(req & ~own_mask));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      D_GRANTS <= '0;
      D_WAIT   <= '0;
    end else begin
      if (state == IDLE && any_req &&
          D_GRANTS[int'(pick)*16 +: 16] != 16'hFFFF) begin
        D_GRANTS[int'(pick)*16 +: 16] <=
          D_GRANTS[int'(pick)*16 +: 16] + 16'd1;
      end
      if (waiting && D_WAIT != 16'hFFFF) begin
        D_WAIT <= D_WAIT + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter against a burst-level ownership model.
module tb_mem_arbiter;
  localparam int P  = 2;
  localparam int DW = 10;
  localparam int AW = 14;
  localparam int PL = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_arbiter_if #(.PORTS(P), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  logic [PL-1:0] d_owner;
  logic [1:0]    d_state;
`ifdef MEM_ARB_STATS_EN
  logic [P*16-1:0] d_grants;
  logic [15:0]     d_wait;
`endif

  mem_arbiter #(
    .PORTS(P), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .PORT_LEN(PL)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus),
    .D_OWNER(d_owner),
    .D_STATE(d_state)
`ifdef MEM_ARB_STATS_EN
    ,
    .D_GRANTS(d_grants),
    .D_WAIT(d_wait)
`endif
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  // Model: who owns the bus, whether the owner's request has lapsed
  // for one cycle, and the next starting point of the search.
  bit m_busy;
  bit m_tail;
  int m_owner;
  int m_ptr;
  int m_grants[P];
  int m_wait;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_busy  = 0;
    m_tail  = 0;
    m_owner = 0;
    m_ptr   = 0;
    m_wait  = 0;
    for (int p = 0; p < P; p++) m_grants[p] = 0;
  endtask

  task automatic model_step();
    logic [P-1:0] r;
    logic [P-1:0] others;
    int cand;
    r = bus.req_read | bus.req_write;
    others = r & ~(P'(1) << m_owner);
    if (m_busy && others != 0 && m_wait < 65535) m_wait++;
    if (!m_busy) begin
      for (int k = 0; k < P; k++) begin
        cand = (m_ptr + k) % P;
        if (r[cand]) begin
          m_owner = cand;
          m_busy  = 1;
          m_tail  = 0;
          if (m_grants[cand] < 65535) m_grants[cand]++;
          break;
        end
      end
    end else if (m_tail) begin
      if (r[m_owner]) begin
        m_tail = 0;
      end else begin
        m_busy = 0;
        m_tail = 0;
        m_ptr  = (m_owner + 1) % P;
      end
    end else if (!r[m_owner]) begin
      m_tail = 1;
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  task automatic compare();
    logic [P-1:0] eg;
    bit ewr;
    bit erd;
    eg  = m_busy ? (P'(1) << m_owner) : '0;
    ewr = m_busy && bus.req_write[m_owner];
    erd = m_busy && bus.req_read[m_owner] && !ewr;
    chk("grant", bus.grant, eg);
    chk("d_state", d_state, !m_busy ? 0 : (m_tail ? 2 : 1));
    chk("d_owner", d_owner, m_owner);
    chk("ram_write", bus.ram_write, ewr);
    chk("ram_read", bus.ram_read, erd);
    chk("ram_addr", bus.ram_addr,
        m_busy ? bus.req_addr[m_owner*AW +: AW] : '0);
    chk("ram_data_in", bus.ram_data_in,
        m_busy ? bus.req_wdata[m_owner*DW +: DW] : '0);
    chk("rdata", bus.rdata, bus.ram_data_out);
`ifdef MEM_ARB_STATS_EN
    for (int p = 0; p < P; p++)
      chk("d_grants", d_grants[p*16 +: 16], m_grants[p]);
    chk("d_wait", d_wait, m_wait);
`endif
  endtask

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      compare();
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    bus.ram_data_out = DW'($urandom);
  endtask

  task automatic set_port(int p, bit rd, bit wr,
                          logic [AW-1:0] a, logic [DW-1:0] d);
    bus.req_read[p]            = rd;
    bus.req_write[p]           = wr;
    bus.req_addr[p*AW +: AW]   = a;
    bus.req_wdata[p*DW +: DW]  = d;
  endtask

  task automatic clr();
    for (int p = 0; p < P; p++) set_port(p, 0, 0, '0, '0);
  endtask

  task automatic do_reset();
    #1 rst_n = 1'b0;
    clr();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Caches that hold req until granted for len cycles, then release.
  task automatic contend(input int l0, input int l1,
                         output int first_g, output int gap,
                         inout int waited);
    int cnt[P];
    logic [P-1:0] gq[$];
    logic [P-1:0] g;
    bit want;
    bit done;
    int last0;
    int first1;
    for (int p = 0; p < P; p++) cnt[p] = 0;
    done = 0;
    for (int n = 0; n < 400 && !done; n++) begin
      for (int p = 0; p < P; p++) begin
        want = cnt[p] < ((p == 0) ? l0 : l1);
        set_port(p, want, want && ($urandom_range(0, 1) == 1),
                 AW'($urandom), DW'($urandom));
      end
      @(negedge clk);
      g = bus.grant;
      gq.push_back(g);
      if (g == 2'b01 && bus.req_read[1]) waited++;
      for (int p = 0; p < P; p++) if (g[p]) cnt[p]++;
      done = cnt[0] >= l0 && cnt[1] >= l1 && g == '0;
      tick();
    end
    chk("contend_done", done, 1);
    first_g = 0;
    last0   = -1;
    first1  = -1;
    foreach (gq[i]) begin
      if (first_g == 0 && gq[i] != 0) first_g = int'(gq[i]);
      if (gq[i] == 2'b01) last0 = i;
      if (gq[i] == 2'b10 && first1 < 0) first1 = i;
    end
    gap = first1 - last0 - 1;
  endtask

  initial begin
    int fg;
    int gp;
    int waited;
    bit seen_idle;
    bit lost_grant;
    logic [1:0] rk;

    bus.ram_data_out = '0;
    clr();
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_grant", bus.grant, 2'b00);
      chk("idle_state", d_state, 2'd0);
      chk("idle_ram_rd", bus.ram_read, 1'b0);
      tick();
    end

    for (int i = 0; i < 32; i++) begin
      set_port(0, 1, 0, AW'(14'h0040 + i), '0);
      @(negedge clk);
      if (i == 0) chk("rd_no_early_grant", bus.grant, 2'b00);
      if (i == 1 || i == 31) begin
        chk("rd_grant", bus.grant, 2'b01);
        chk("rd_addr", bus.ram_addr, 14'h0040 + i);
        chk("rd_strobe", bus.ram_read, 1'b1);
      end
      tick();
    end
    clr();
    @(negedge clk);
    chk("rd_last_own", d_state, 2'd1);
    tick();
    @(negedge clk);
    chk("rd_tail_state", d_state, 2'd2);
    chk("rd_tail_grant", bus.grant, 2'b01);
    tick();
    @(negedge clk);
    chk("rd_released", bus.grant, 2'b00);
    chk("rd_idle", d_state, 2'd0);
    tick();

    seen_idle  = 0;
    lost_grant = 0;
    for (int i = 0; i < 32; i++) begin
      set_port(1, 0, 1, AW'($urandom), DW'(10'h3FF - i));
      @(negedge clk);
      if (i == 5) begin
        chk("wb_write", bus.ram_write, 1'b1);
        chk("wb_data", bus.ram_data_in, 10'h3FA);
      end
      if (i > 0 && d_state == 2'd0) seen_idle = 1;
      if (i > 0 && bus.grant != 2'b10) lost_grant = 1;
      tick();
    end
    clr();
    @(negedge clk);
    tick();
    for (int i = 0; i < 32; i++) begin
      set_port(1, 1, 0, AW'($urandom), '0);
      @(negedge clk);
      if (d_state == 2'd0) seen_idle = 1;
      if (bus.grant != 2'b10) lost_grant = 1;
      tick();
    end
    clr();
    repeat (2) begin
      @(negedge clk);
      if (bus.grant != 2'b10) lost_grant = 1;
      tick();
    end
    chk("wb_fill_no_idle", seen_idle, 0);
    chk("wb_fill_grant_held", lost_grant, 0);

    do_reset();
    waited = 0;
    contend(6, 4, fg, gp, waited);
    chk("contend1_first", fg, 1);
    chk("contend1_gap", gp, 1);
    contend(3, 5, fg, gp, waited);
    chk("contend2_first", fg, 1);
    chk("contend2_gap", gp, 1);

`ifdef MEM_ARB_STATS_EN
    do_reset();
    waited = 0;
    repeat (3) contend(int'($urandom_range(2, 9)),
                       int'($urandom_range(2, 9)), fg, gp, waited);
    chk("stats_grants0", d_grants[15:0], 16'd3);
    chk("stats_grants1", d_grants[31:16], 16'd3);
    chk("stats_wait", d_wait, waited);
`endif

    do_reset();
    set_port(1, 0, 1, 14'h1234, 10'h155);
    tick();
    tick();
    chk("mid_pre_grant", bus.grant, 2'b10);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_grant", bus.grant, 2'b00);
    chk("mid_write", bus.ram_write, 1'b0);
    chk("mid_owner", d_owner, 1'b0);
    clr();
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_after_state", d_state, 2'd0);
    chk("mid_after_owner", d_owner, 1'b0);
    tick();

    for (int n = 0; n < 3000; n++) begin
      for (int p = 0; p < P; p++) begin
        if ($urandom_range(0, 3) == 0) begin
          rk = 2'($urandom);
          bus.req_read[p]  = rk[0];
          bus.req_write[p] = rk[1];
        end
        bus.req_addr[p*AW +: AW]  = AW'($urandom);
        bus.req_wdata[p*DW +: DW] = DW'($urandom);
      end
      if ($urandom_range(0, 499) == 0) begin
        #1 rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
      end else begin
        tick();
      end
    end

    for (int r = 0; r < 6; r++) begin
      clr();
      tick();
      contend(int'($urandom_range(1, 12)),
              int'($urandom_range(1, 12)), fg, gp, waited);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
